// File: rtl/pht_update_ctrl.sv
// rtl/pht_update_ctrl.sv - PHT 2-bit counter read-modify-write sequencer
// Two arbitrated update requesters share a single-port SRAM with the lookup path.
module pht_update_ctrl #(
   parameter int IDX_W      = 10,
   parameter int CNT_W      = 2,
   parameter int STARVE_LIM = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             upd0_valid_i,
   output logic             upd0_ready_o,
   input  logic [IDX_W-1:0] upd0_idx_i,
   input  logic             upd0_taken_i,
   input  logic             upd1_valid_i,
   output logic             upd1_ready_o,
   input  logic [IDX_W-1:0] upd1_idx_i,
   input  logic             upd1_taken_i,
   input  logic             lkp_valid_i,
   output logic             lkp_ready_o,
   input  logic [IDX_W-1:0] lkp_idx_i,
   output logic             lkp_cnt_valid_o,
   output logic [CNT_W-1:0] lkp_cnt_o,
   output logic             pht_ce_o,
   output logic             pht_we_o,
   output logic [IDX_W-1:0] pht_addr_o,
   output logic [CNT_W-1:0] pht_wdata_o,
   input  logic [CNT_W-1:0] pht_rdata_i,
   output logic             busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_MOD, S_WR} state_t;

   localparam int SC_W = $clog2(STARVE_LIM + 1);
   localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIM);

   state_t           state_q, state_d;
   logic             rr_q, rr_d;
   logic [SC_W-1:0]  starve_q, starve_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             taken_q, taken_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lkp_rv_q, lkp_rv_d;

   logic             grant0, grant1, lkp_win, upd_phase;
   logic             upd0_ready, upd1_ready;

   function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input logic t);
      if (t) return (c == '1) ? c : c + 1'b1;
      else   return (c == '0) ? c : c - 1'b1;
   endfunction

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      starve_d    = starve_q;
      idx_d       = idx_q;
      taken_d     = taken_q;
      cnt_d       = cnt_q;
      upd0_ready  = 1'b0;
      upd1_ready  = 1'b0;
      pht_ce_o    = 1'b0;
      pht_we_o    = 1'b0;
      pht_addr_o  = '0;
      pht_wdata_o = '0;

      grant0    = upd0_valid_i & (~upd1_valid_i | ~rr_q);
      grant1    = upd1_valid_i & (~upd0_valid_i | rr_q);
      upd_phase = (state_q == S_RD) || (state_q == S_WR);
      // Lookups only yield to an update once it has been blocked STARVE_LIM cycles in a row
      lkp_win   = lkp_valid_i & (~upd_phase | (starve_q != STARVE_MAX));
      lkp_rv_d  = lkp_win;

      if (lkp_win) begin
         pht_ce_o   = 1'b1;
         pht_addr_o = lkp_idx_i;
      end

      case (state_q)
         S_IDLE: begin
            starve_d = '0;
            if (grant0) begin
               upd0_ready = 1'b1;
               idx_d      = upd0_idx_i;
               taken_d    = upd0_taken_i;
               rr_d       = 1'b1;
               state_d    = S_RD;
            end else if (grant1) begin
               upd1_ready = 1'b1;
               idx_d      = upd1_idx_i;
               taken_d    = upd1_taken_i;
               rr_d       = 1'b0;
               state_d    = S_RD;
            end
         end
         S_RD: begin
            if (lkp_win) begin
               starve_d = starve_q + 1'b1;
            end else begin
               pht_ce_o   = 1'b1;
               pht_addr_o = idx_q;
               starve_d   = '0;
               state_d    = S_MOD;
            end
         end
         S_MOD: begin
            starve_d = '0;
            cnt_d    = pht_rdata_i;
            state_d  = S_WR;
         end
         S_WR: begin
            if (lkp_win) begin
               starve_d = starve_q + 1'b1;
            end else begin
               pht_ce_o    = 1'b1;
               pht_we_o    = 1'b1;
               pht_addr_o  = idx_q;
               pht_wdata_o = sat(cnt_q, taken_q);
               starve_d    = '0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         rr_q     <= 1'b0;
         starve_q <= '0;
         idx_q    <= '0;
         taken_q  <= 1'b0;
         cnt_q    <= '0;
         lkp_rv_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         starve_q <= starve_d;
         idx_q    <= idx_d;
         taken_q  <= taken_d;
         cnt_q    <= cnt_d;
         lkp_rv_q <= lkp_rv_d;
      end
   end

   // Handshake outputs follow request valids combinationally, so hold them low during reset
   assign upd0_ready_o    = upd0_ready & ~rst_i;
   assign upd1_ready_o    = upd1_ready & ~rst_i;
   assign lkp_ready_o     = lkp_win & ~rst_i;
   assign lkp_cnt_valid_o = lkp_rv_q;
   assign lkp_cnt_o       = lkp_rv_q ? pht_rdata_i : '0;
   assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_pht_update_ctrl.sv
// tb/tb_pht_update_ctrl.sv - self-checking bench for pht_update_ctrl
// Behavioural single-port SRAM with registered read data.
module tb_pht_update_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       upd0_valid_i, upd0_ready_o, upd0_taken_i;
   logic [9:0] upd0_idx_i;
   logic       upd1_valid_i, upd1_ready_o, upd1_taken_i;
   logic [9:0] upd1_idx_i;
   logic       lkp_valid_i, lkp_ready_o, lkp_cnt_valid_o;
   logic [9:0] lkp_idx_i;
   logic [1:0] lkp_cnt_o;
   logic       pht_ce_o, pht_we_o;
   logic [9:0] pht_addr_o;
   logic [1:0] pht_wdata_o;
   logic [1:0] pht_rdata_i;
   logic       busy_o;

   logic [1:0] mem [1024];
   logic       pl_en;
   logic [9:0] pl_addr;
   logic [1:0] pl_data;

   int checks = 0;
   int errors = 0;

   pht_update_ctrl #(.IDX_W(10), .CNT_W(2), .STARVE_LIM(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .upd0_valid_i(upd0_valid_i), .upd0_ready_o(upd0_ready_o),
      .upd0_idx_i(upd0_idx_i), .upd0_taken_i(upd0_taken_i),
      .upd1_valid_i(upd1_valid_i), .upd1_ready_o(upd1_ready_o),
      .upd1_idx_i(upd1_idx_i), .upd1_taken_i(upd1_taken_i),
      .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o), .lkp_idx_i(lkp_idx_i),
      .lkp_cnt_valid_o(lkp_cnt_valid_o), .lkp_cnt_o(lkp_cnt_o),
      .pht_ce_o(pht_ce_o), .pht_we_o(pht_we_o), .pht_addr_o(pht_addr_o),
      .pht_wdata_o(pht_wdata_o), .pht_rdata_i(pht_rdata_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (pht_ce_o && pht_we_o) mem[pht_addr_o] <= pht_wdata_o;
      if (pht_ce_o && !pht_we_o) pht_rdata_i <= mem[pht_addr_o];
   end

   typedef struct {
      int         req;
      logic [9:0] idx;
      logic       taken;
      logic [1:0] init;
      logic [1:0] exp_w;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [9:0] a, input logic [1:0] d);
      @(negedge clk_i);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk_i);
      pl_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic do_update(input int req, input logic [9:0] idx, input logic taken,
                            output logic [1:0] wd, output logic [9:0] wa);
      bit ok;
      wd = '0; wa = '0;
      @(negedge clk_i);
      if (req == 0) begin upd0_valid_i = 1'b1; upd0_idx_i = idx; upd0_taken_i = taken; end
      else          begin upd1_valid_i = 1'b1; upd1_idx_i = idx; upd1_taken_i = taken; end
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if ((req == 0) ? upd0_ready_o : upd1_ready_o) begin ok = 1'b1; break; end
         @(negedge clk_i);
      end
      chk("handshake", 32'(ok), 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      upd0_valid_i = 1'b0; upd1_valid_i = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (pht_ce_o && pht_we_o) begin wd = pht_wdata_o; wa = pht_addr_o; ok = 1'b1; break; end
         @(negedge clk_i);
      end
      chk("write_seen", 32'(ok), 32'd1);
      @(negedge clk_i);
      #1;
      chk("idle_after_write", 32'(busy_o), 32'd0);
   endtask

   initial begin
      logic [1:0] wd;
      logic [9:0] wa;
      int gw[8];
      int gc[8];
      int ng;
      int both;

      vecs[0] = '{0, 10'h005, 1'b1, 2'd1, 2'd2};
      vecs[1] = '{1, 10'h010, 1'b1, 2'd3, 2'd3};
      vecs[2] = '{0, 10'h3FF, 1'b0, 2'd0, 2'd0};
      vecs[3] = '{1, 10'h020, 1'b0, 2'd2, 2'd1};
      vecs[4] = '{0, 10'h021, 1'b0, 2'd3, 2'd2};
      vecs[5] = '{1, 10'h000, 1'b1, 2'd0, 2'd1};
      vecs[6] = '{0, 10'h022, 1'b1, 2'd2, 2'd3};

      upd0_valid_i = 0; upd0_idx_i = 0; upd0_taken_i = 0;
      upd1_valid_i = 0; upd1_idx_i = 0; upd1_taken_i = 0;
      lkp_valid_i = 0; lkp_idx_i = 0;
      pl_en = 0; pl_addr = 0; pl_data = 0;
      rst_i = 1'b1;
      #12;
      chk("rst_ce", 32'(pht_ce_o), 0);
      chk("rst_we", 32'(pht_we_o), 0);
      chk("rst_addr", 32'(pht_addr_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_lkp_cv", 32'(lkp_cnt_valid_o), 0);
      chk("rst_lkp_cnt", 32'(lkp_cnt_o), 0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // single update, cycle by cycle
      preload(10'h005, 2'd1);
      @(negedge clk_i);
      upd0_valid_i = 1; upd0_idx_i = 10'h005; upd0_taken_i = 1;
      #1;
      chk("single_rdy0", 32'(upd0_ready_o), 1);
      chk("single_rdy1", 32'(upd1_ready_o), 0);
      chk("single_busy_T", 32'(busy_o), 0);
      @(negedge clk_i);
      upd0_valid_i = 0;
      #1;
      chk("single_rd_ce", 32'({pht_ce_o, pht_we_o}), 32'b10);
      chk("single_rd_addr", 32'(pht_addr_o), 32'h005);
      chk("single_busy_T1", 32'(busy_o), 1);
      @(negedge clk_i); #1;
      chk("single_mod_ce", 32'(pht_ce_o), 0);
      chk("single_busy_T2", 32'(busy_o), 1);
      @(negedge clk_i); #1;
      chk("single_wr_cewe", 32'({pht_ce_o, pht_we_o}), 32'b11);
      chk("single_wr_addr", 32'(pht_addr_o), 32'h005);
      chk("single_wr_data", 32'(pht_wdata_o), 2);
      chk("single_busy_T3", 32'(busy_o), 1);
      @(negedge clk_i); #1;
      chk("single_busy_T4", 32'(busy_o), 0);
      chk("single_ce_T4", 32'(pht_ce_o), 0);
      chk("single_mem", 32'(mem[10'h005]), 2);

      // table of saturating updates
      for (int v = 0; v < 7; v++) begin
         preload(vecs[v].idx, vecs[v].init);
         do_update(vecs[v].req, vecs[v].idx, vecs[v].taken, wd, wa);
         chk($sformatf("vec%0d_wdata", v), 32'(wd), 32'(vecs[v].exp_w));
         chk($sformatf("vec%0d_waddr", v), 32'(wa), 32'(vecs[v].idx));
         chk($sformatf("vec%0d_mem", v), 32'(mem[vecs[v].idx]), 32'(vecs[v].exp_w));
      end

      // back-to-back to one index sees the prior write
      preload(10'h040, 2'd1);
      do_update(0, 10'h040, 1'b1, wd, wa);
      chk("b2b_first", 32'(wd), 2);
      do_update(1, 10'h040, 1'b1, wd, wa);
      chk("b2b_second", 32'(wd), 3);

      // round-robin arbitration
      do_reset();
      ng = 0; both = 0;
      @(negedge clk_i);
      upd0_valid_i = 1; upd0_idx_i = 10'h100; upd0_taken_i = 1;
      upd1_valid_i = 1; upd1_idx_i = 10'h101; upd1_taken_i = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (upd0_ready_o && upd1_ready_o) both++;
         if (ng < 8 && (upd0_ready_o || upd1_ready_o)) begin
            gw[ng] = upd0_ready_o ? 0 : 1;
            gc[ng] = c;
            ng++;
         end
         @(negedge clk_i);
      end
      upd0_valid_i = 0; upd1_valid_i = 0;
      chk("arb_both_ready", 32'(both), 0);
      chk("arb_grants", 32'(ng >= 4), 1);
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("arb_who%0d", g), 32'(gw[g]), 32'(g % 2));
         chk($sformatf("arb_cyc%0d", g), 32'(gc[g]), 32'(4 * g));
      end
      for (int i = 0; i < 10 && busy_o; i++) @(negedge clk_i);

      // lookup priority for three cycles in RD
      preload(10'h007, 2'd2);
      preload(10'h030, 2'd1);
      @(negedge clk_i);
      upd0_valid_i = 1; upd0_idx_i = 10'h030; upd0_taken_i = 0;
      #1;
      chk("lp_rdy", 32'(upd0_ready_o), 1);
      @(negedge clk_i);
      upd0_valid_i = 0;
      for (int k = 0; k < 3; k++) begin
         lkp_valid_i = 1; lkp_idx_i = 10'h007;
         #1;
         chk($sformatf("lp_ready%0d", k), 32'(lkp_ready_o), 1);
         chk($sformatf("lp_port%0d", k), 32'({pht_ce_o, pht_we_o, pht_addr_o}), 32'({2'b10, 10'h007}));
         if (k > 0) chk($sformatf("lp_data%0d", k), 32'({lkp_cnt_valid_o, lkp_cnt_o}), 32'({1'b1, 2'd2}));
         @(negedge clk_i);
      end
      lkp_valid_i = 0;
      #1;
      chk("lp_last_data", 32'({lkp_cnt_valid_o, lkp_cnt_o}), 32'({1'b1, 2'd2}));
      chk("lp_upd_read", 32'({pht_ce_o, pht_we_o, pht_addr_o}), 32'({2'b10, 10'h030}));
      @(negedge clk_i); #1;
      chk("lp_mod_ce", 32'({pht_ce_o, lkp_cnt_valid_o}), 0);
      @(negedge clk_i); #1;
      chk("lp_write", 32'({pht_we_o, pht_addr_o, pht_wdata_o}), 32'({1'b1, 10'h030, 2'd0}));
      @(negedge clk_i); #1;
      chk("lp_done", 32'(busy_o), 0);

      // starvation guard in RD and WR
      preload(10'h008, 2'd1);
      preload(10'h031, 2'd3);
      @(negedge clk_i);
      upd1_valid_i = 1; upd1_idx_i = 10'h031; upd1_taken_i = 1;
      #1;
      chk("sv_rdy1", 32'(upd1_ready_o), 1);
      @(negedge clk_i);
      upd1_valid_i = 0; lkp_valid_i = 1; lkp_idx_i = 10'h008;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("sv_rd_lkp%0d", i), 32'({lkp_ready_o, pht_addr_o}), 32'({1'b1, 10'h008}));
         @(negedge clk_i);
      end
      #1;
      chk("sv_rd_forced", 32'({lkp_ready_o, pht_ce_o, pht_we_o, pht_addr_o}), 32'({3'b010, 10'h031}));
      @(negedge clk_i); #1;
      chk("sv_mod_lkp", 32'({lkp_ready_o, lkp_cnt_valid_o}), 32'b10);
      @(negedge clk_i);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("sv_wr_lkp%0d", i), 32'({lkp_ready_o, pht_we_o}), 32'b10);
         if (i == 0) chk("sv_mod_lkp_data", 32'({lkp_cnt_valid_o, lkp_cnt_o}), 32'({1'b1, 2'd1}));
         @(negedge clk_i);
      end
      #1;
      chk("sv_wr_forced", 32'({lkp_ready_o, pht_we_o, pht_addr_o, pht_wdata_o}), 32'({2'b01, 10'h031, 2'd3}));
      @(negedge clk_i);
      lkp_valid_i = 0;
      #1;
      chk("sv_done", 32'(busy_o), 0);

      // reset in WR drops the write
      preload(10'h055, 2'd1);
      @(negedge clk_i);
      upd0_valid_i = 1; upd0_idx_i = 10'h055; upd0_taken_i = 1;
      #1;
      chk("rm_rdy", 32'(upd0_ready_o), 1);
      @(negedge clk_i);
      upd0_valid_i = 0;
      @(negedge clk_i);
      @(negedge clk_i); #1;
      chk("rm_in_wr", 32'(pht_we_o), 1);
      rst_i = 1'b1;
      #1;
      chk("rm_outs", 32'({pht_ce_o, pht_we_o, pht_addr_o, pht_wdata_o, busy_o,
                          lkp_cnt_valid_o, lkp_cnt_o, lkp_ready_o, upd0_ready_o, upd1_ready_o}), 0);
      @(negedge clk_i);
      chk("rm_no_write", 32'(mem[10'h055]), 1);
      rst_i = 1'b0;
      upd0_valid_i = 1; upd0_idx_i = 10'h055; upd0_taken_i = 1;
      upd1_valid_i = 1; upd1_idx_i = 10'h056; upd1_taken_i = 1;
      #1;
      chk("rm_rr0", 32'({upd0_ready_o, upd1_ready_o}), 32'b10);
      @(negedge clk_i);
      upd0_valid_i = 0; upd1_valid_i = 0;
      for (int i = 0; i < 10 && busy_o; i++) @(negedge clk_i);
      #1;
      chk("rm_idle", 32'(busy_o), 0);
      chk("rm_after", 32'(mem[10'h055]), 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pht_update_ctrl.md
Name: pht_update_ctrl

Overview:
- Sequences read-modify-write updates of 2-bit saturating counters held in a single-port pattern history table (PHT) SRAM inside the BPU.
- Two branch-resolution requesters share the update path through a round-robin arbiter.
- The front-end lookup port shares the same SRAM port and normally has priority over updates.
- A starvation guard bounds how long lookups can block an in-flight update.

Parameters:
- IDX_W, 10, PHT index width (table depth 2^IDX_W).
- CNT_W, 2, counter width; saturates at 0 and 2^CNT_W-1.
- STARVE_LIM, 8, consecutive lookup-blocked cycles before the update port is forced (≥1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- upd0_valid_i  in  1  resolution request 0 valid
- upd0_ready_o  out  1  request 0 accepted this cycle
- upd0_idx_i  in  IDX_W  PHT index for request 0
- upd0_taken_i  in  1  resolved direction for request 0
- upd1_valid_i / upd1_ready_o / upd1_idx_i / upd1_taken_i  same as request 0, for requester 1
- lkp_valid_i  in  1  prediction lookup request
- lkp_ready_o  out  1  lookup granted the SRAM port
- lkp_idx_i  in  IDX_W  lookup index
- lkp_cnt_valid_o  out  1  lookup data valid
- lkp_cnt_o  out  CNT_W  lookup counter value
- pht_ce_o  out  1  SRAM chip enable
- pht_we_o  out  1  SRAM write enable
- pht_addr_o  out  IDX_W  SRAM address
- pht_wdata_o  out  CNT_W  SRAM write data
- pht_rdata_i  in  CNT_W  SRAM read data, valid the cycle after a read
- busy_o  out  1  update in flight (state != IDLE)

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is asynchronous and active-high.
- Reset values:
  - all outputs 0
  - FSM = IDLE
  - rr_ptr = 0
  - starve_cnt = 0
  - latched idx/taken/cnt = 0
- FSM states:
  - IDLE: arbitrate; on handshake latch idx and taken → RD.
  - RD: issue read (ce=1, we=0, addr=idx) if port won → MOD; else hold.
  - MOD: cnt_q ← pht_rdata_i; unconditional → WR.
  - WR: issue write (ce=1, we=1, addr=idx, wdata=sat(cnt_q, taken)) if port won → IDLE; else hold.
- Arbitration in IDLE:
  - Both valid: grant the requester selected by rr_ptr.
  - One valid: grant that requester.
  - upd*_ready_o is high only in IDLE, for the granted requester only (depends combinationally on valid).
  - After a grant, rr_ptr ← index of the non-granted requester.
- Port sharing:
  - In RD/WR, lkp_valid_i=1 and starve_cnt<STARVE_LIM: lookup wins; lkp_ready_o=1; update holds; starve_cnt increments.
  - In RD/WR, starve_cnt==STARVE_LIM: update wins; lkp_ready_o=0 (requester retries); starve_cnt ← 0.
  - starve_cnt clears whenever the update wins the port, and in IDLE/MOD.
  - In IDLE/MOD: lkp_ready_o = lkp_valid_i.
- Lookup data:
  - Granted lookup drives ce=1, we=0, addr=lkp_idx_i.
  - Next cycle: lkp_cnt_valid_o=1 and lkp_cnt_o=pht_rdata_i; otherwise lkp_cnt_o=0.
  - A lookup granted in RD/WR returns data while the FSM is still in RD/WR.
  - A lookup granted in MOD returns data in the following cycle (WR or IDLE), so a lookup return never collides with an update read return.
- Saturation sat(c,t):
  - t=1 and c=max → max; t=1 otherwise → c+1.
  - t=0 and c=0 → 0; t=0 otherwise → c-1.
  - Width CNT_W, no wrap.
- Latency: handshake at cycle T, read T+1, capture T+2, write T+3, back in IDLE at T+4. Each lookup-won cycle adds one cycle.
- Throughput: one update per 4 cycles unstalled. Back-to-back updates to the same index see the prior write, with no RAW hazard.
- A lookup to an index with an update in flight returns the pre-update value. This is by design.
- Reset asserted mid-operation: the in-flight update is dropped with no write; outputs clear immediately (asynchronous).
- pht_we_o=1 only in WR when the update wins the port; pht_ce_o=0 when nothing uses the port.

Test Plan:
- Single update: idx=0x05, taken=1, SRAM holds 1 → read at T+1, write 2 at T+3, busy_o high T+1..T+3.
- Saturation: taken=1 on value 3 → write 3; taken=0 on value 0 → write 0; taken=0 on value 2 → write 1.
- Arbitration: both requesters valid continuously after reset → grants alternate 0,1,0,1, one grant every 4 cycles, ready never high for both.
- Lookup priority: lkp_valid_i held for 3 cycles starting in RD → 3 lookups served, each with lkp_cnt_valid_o the next cycle; read issued in the 4th cycle; write data still correct.
- Starvation: lkp_valid_i held continuously with STARVE_LIM=8 from RD → 8 lookups granted, lkp_ready_o=0 on cycle 9 and the update read issues; same pattern repeats in WR; update completes.
- Reset mid-update: rst_i pulsed in WR with lookup idle → no write, all outputs 0, FSM IDLE, rr_ptr=0; a new request afterwards completes normally.
